// File: rtl/keypad_scan_encoder_if.sv
// Keypad pin bundle plus the encoded key-code output toward the lock controller.
interface keypad_scan_encoder_if;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] code;
  logic       key_valid;

  modport master (output col_n, input row_n, input code, input key_valid);
  modport slave  (input col_n, output row_n, output code, output key_valid);
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x3 matrix keypad scanner: row rotation, column synchronizer, press/release
// debounce and a single-cycle key-code pulse per accepted press.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keypad_scan_encoder_if.slave bus
);
  localparam int unsigned      DIV_W      = $clog2(SCAN_DIV);
  localparam int unsigned      DEB_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       IDLE_CODE  = 4'b1111;
  localparam logic [2:0]       COLS_IDLE  = 3'b111;

  typedef enum logic [1:0] { SCAN, DEBOUNCE, EMIT, RELEASE } state_t;

  state_t           state, state_next;
  logic [2:0]       col_meta, cs;
  logic [1:0]       row_idx, row_next;
  logic [DIV_W-1:0] dwell_cnt, dwell_next;
  logic [DEB_W-1:0] deb_cnt, deb_next;
  logic [2:0]       key_pat, pat_next;
  logic [3:0]       row_n_q, row_n_next;
  logic [3:0]       code_q, code_next;
  logic             key_valid_q, valid_next;
  logic             single_low;

  // Row 3 carries the non-digit keys; rows 0-2 are digits 1-9 in reading order.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [2:0] pat);
    logic [3:0] col;
    col = (pat == 3'b110) ? 4'd0 : (pat == 3'b101) ? 4'd1 : 4'd2;
    if (row == 2'd3) begin
      key_code = (col == 4'd0) ? 4'b1101 : (col == 4'd1) ? 4'b0000 : 4'b1110;
    end else begin
      key_code = {2'b00, row} * 4'd3 + col + 4'd1;
    end
  endfunction

  assign single_low = (cs == 3'b110) || (cs == 3'b101) || (cs == 3'b011);

  assign bus.row_n     = row_n_q;
  assign bus.code      = code_q;
  assign bus.key_valid = key_valid_q;

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= COLS_IDLE;
      cs       <= COLS_IDLE;
    end else begin
      col_meta <= bus.col_n;
      cs       <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      row_idx     <= 2'd0;
      dwell_cnt   <= '0;
      deb_cnt     <= '0;
      key_pat     <= COLS_IDLE;
      row_n_q     <= 4'b1110;
      code_q      <= IDLE_CODE;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      row_idx     <= row_next;
      dwell_cnt   <= dwell_next;
      deb_cnt     <= deb_next;
      key_pat     <= pat_next;
      row_n_q     <= row_n_next;
      code_q      <= code_next;
      key_valid_q <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    row_next   = row_idx;
    dwell_next = dwell_cnt;
    deb_next   = deb_cnt;
    pat_next   = key_pat;

    unique case (state)
      SCAN: begin
        // Columns are judged only at the end of the dwell so the row has settled.
        if (dwell_cnt == DWELL_LAST) begin
          dwell_next = '0;
          if (single_low) begin
            pat_next   = cs;
            deb_next   = '0;
            state_next = DEBOUNCE;
          end else begin
            row_next = row_idx + 2'd1;
          end
        end else begin
          dwell_next = dwell_cnt + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (cs == key_pat) begin
          if (deb_cnt == DEB_LAST) begin
            state_next = EMIT;
          end else begin
            deb_next = deb_cnt + DEB_W'(1);
          end
        end else begin
          state_next = SCAN;
          row_next   = row_idx + 2'd1;
          dwell_next = '0;
        end
      end
      EMIT: begin
        state_next = RELEASE;
        deb_next   = '0;
      end
      RELEASE: begin
        // Held row stays driven until every column has been idle long enough.
        if (cs == COLS_IDLE) begin
          if (deb_cnt == DEB_LAST) begin
            state_next = SCAN;
            row_next   = row_idx + 2'd1;
            dwell_next = '0;
          end else begin
            deb_next = deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_next = '0;
        end
      end
      default: begin
        state_next = SCAN;
      end
    endcase

    row_n_next = ~(4'b0001 << row_next);
    valid_next = (state_next == EMIT);
    code_next  = valid_next ? key_code(row_next, pat_next) : IDLE_CODE;
  end
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench: randomized keypad activity against a countdown-style
// behavioural model of the scanner, plus scenario-specific pulse checks.
module tb_keypad_scan_encoder;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 8;
  localparam logic [3:0]  IDLE     = 4'b1111;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] keys  = '0;
  int          vectors     = 0;
  int          miscompares = 0;

  keypad_scan_encoder_if bus ();

  keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row to its column.
  function automatic logic [2:0] panel(input logic [3:0] rows_n, input logic [11:0] k);
    logic [2:0] c;
    c = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 3; cc++)
        if (!rows_n[r] && k[r*3+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  always_comb bus.col_n = panel(bus.row_n, keys);

  // Reference model: row pointer, countdown dwell and run-length counters.
  int         m_row    = 0;
  int         m_dwell  = int'(SCAN_DIV);
  int         m_stable = 0;
  bit         m_locked = 1'b0;
  bit         m_pressed = 1'b0;
  bit         m_skip   = 1'b0;
  logic [2:0] m_pat    = 3'b111;
  logic [2:0] m_cs     = 3'b111;
  logic [2:0] d1       = 3'b111;
  logic [2:0] d2       = 3'b111;
  logic [3:0] m_code   = IDLE;
  logic       m_valid  = 1'b0;

  function automatic logic [3:0] expected_code(input int r, input logic [2:0] pat);
    int c;
    c = (pat == 3'b110) ? 0 : (pat == 3'b101) ? 1 : 2;
    if (r < 3) return 4'(r * 3 + c + 1);
    return (c == 0) ? 4'd13 : (c == 1) ? 4'd0 : 4'd14;
  endfunction

  function automatic logic [3:0] exp_row_n();
    return 4'(~(4'b0001 << m_row));
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_row = 0; m_dwell = int'(SCAN_DIV); m_stable = 0;
      m_locked = 1'b0; m_pressed = 1'b0; m_skip = 1'b0;
      m_pat = 3'b111; d1 = 3'b111; d2 = 3'b111;
      m_code = IDLE; m_valid = 1'b0;
    end else begin
      m_cs = d2;
      d2 = d1;
      d1 = panel(4'(~(4'b0001 << m_row)), keys);
      m_code = IDLE;
      m_valid = 1'b0;
      if (!m_locked) begin
        if (m_dwell == 1) begin
          m_dwell = int'(SCAN_DIV);
          if ($countones(~m_cs) == 1) begin
            m_locked = 1'b1; m_pressed = 1'b0; m_pat = m_cs; m_stable = 0;
          end else begin
            m_row = (m_row + 1) % 4;
          end
        end else begin
          m_dwell--;
        end
      end else if (m_skip) begin
        m_skip = 1'b0;
      end else if (!m_pressed) begin
        if (m_cs == m_pat) begin
          m_stable++;
          if (m_stable == int'(DEB)) begin
            m_valid = 1'b1; m_code = expected_code(m_row, m_pat);
            m_pressed = 1'b1; m_skip = 1'b1; m_stable = 0;
          end
        end else begin
          m_locked = 1'b0; m_row = (m_row + 1) % 4; m_dwell = int'(SCAN_DIV);
        end
      end else begin
        if (m_cs == 3'b111) begin
          m_stable++;
          if (m_stable == int'(DEB)) begin
            m_locked = 1'b0; m_pressed = 1'b0; m_row = (m_row + 1) % 4;
            m_dwell = int'(SCAN_DIV); m_stable = 0;
          end
        end else begin
          m_stable = 0;
        end
      end
    end
  end

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0;
    keys  = '0;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (bus.row_n !== 4'b1110 || bus.code !== IDLE || bus.key_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: row_n=%b code=%b key_valid=%b, want 1110 1111 0",
                 bus.row_n, bus.code, bus.key_valid);
      end
    end
    rst_n = 1'b1;
    for (int p = 1; p <= 40; p++) begin
      @(negedge clk);
      vectors++;
      exp = 4'(~(4'b0001 << ((p / int'(SCAN_DIV)) % 4)));
      if (bus.row_n !== exp || bus.code !== IDLE || bus.key_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_scan cycle %0d: row_n=%b code=%b key_valid=%b, want %b 1111 0",
                 p, bus.row_n, bus.code, bus.key_valid, exp);
      end
    end
  endtask

  task automatic test_press_five();
    int start, press_at, pulses, pulse_cyc, lock_cyc;
    bit pressed, was_locked;
    logic [3:0] got;
    start = int'($urandom_range(0, 15));
    press_at = -1; pulses = 0; pulse_cyc = -1; lock_cyc = -1;
    pressed = 1'b0; was_locked = 1'b0; got = IDLE;
    for (int cyc = 0; cyc < 280; cyc++) begin
      if (!pressed && cyc >= start && !m_locked && m_row != 1) begin
        keys[4] = 1'b1; pressed = 1'b1; press_at = cyc;
      end
      if (pressed && cyc == press_at + 200) keys[4] = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.row_n !== exp_row_n() || bus.code !== m_code || bus.key_valid !== m_valid) begin
        miscompares++;
        $display("FAIL press5 cycle %0d: row_n=%b code=%b key_valid=%b, want %b %b %b",
                 cyc, bus.row_n, bus.code, bus.key_valid, exp_row_n(), m_code, m_valid);
      end
      if (m_locked && !was_locked && lock_cyc < 0) lock_cyc = cyc;
      was_locked = m_locked;
      if (bus.key_valid === 1'b1) begin
        pulses++; got = bus.code; pulse_cyc = cyc;
      end
    end
    vectors++;
    if (pulses != 1 || got !== 4'b0101) begin
      miscompares++;
      $display("FAIL press5_pulse: pulses=%0d code=%b, want 1 0101", pulses, got);
    end
    vectors++;
    if (pulse_cyc - lock_cyc != int'(DEB)) begin
      miscompares++;
      $display("FAIL press5_latency: %0d cycles after debounce entry, want %0d",
               pulse_cyc - lock_cyc, DEB);
    end
  endtask

  task automatic test_bounce_seven();
    int press_at, pulses, early, hold;
    bit pressed;
    logic [3:0] got;
    press_at = -1; pulses = 0; early = 0; pressed = 1'b0; got = IDLE;
    hold = int'($urandom_range(40, 80));
    for (int cyc = 0; cyc < 260; cyc++) begin
      if (!pressed && !m_locked && m_row != 2) begin
        pressed = 1'b1; press_at = cyc;
      end
      if (pressed) begin
        if (cyc < press_at + 30)             keys[6] = (((cyc - press_at) / 3) % 2) == 0;
        else if (cyc < press_at + 30 + hold) keys[6] = 1'b1;
        else                                 keys[6] = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (bus.row_n !== exp_row_n() || bus.code !== m_code || bus.key_valid !== m_valid) begin
        miscompares++;
        $display("FAIL bounce7 cycle %0d: row_n=%b code=%b key_valid=%b, want %b %b %b",
                 cyc, bus.row_n, bus.code, bus.key_valid, exp_row_n(), m_code, m_valid);
      end
      if (bus.key_valid === 1'b1) begin
        pulses++; got = bus.code;
        if (cyc < press_at + 30) early++;
      end
    end
    keys[6] = 1'b0;
    vectors++;
    if (early != 0 || pulses != 1 || got !== 4'b0111) begin
      miscompares++;
      $display("FAIL bounce7_pulse: early=%0d pulses=%0d code=%b, want 0 1 0111", early, pulses, got);
    end
  endtask

  task automatic test_special_keys();
    logic [3:0] seen[$];
    logic [3:0] want[3];
    want[0] = 4'b1101; want[1] = 4'b0000; want[2] = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      int hold, held;
      bit pressed, done;
      hold = int'($urandom_range(30, 60));
      held = 0; pressed = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
        if (!pressed && !m_locked && m_row != 3) begin
          keys[9+k] = 1'b1; pressed = 1'b1;
        end else if (pressed && keys[9+k] && held >= hold) begin
          keys[9+k] = 1'b0;
        end else if (pressed && !keys[9+k] && !m_locked) begin
          done = 1'b1;
        end
        @(negedge clk);
        vectors++;
        if (bus.row_n !== exp_row_n() || bus.code !== m_code || bus.key_valid !== m_valid) begin
          miscompares++;
          $display("FAIL special%0d cycle %0d: row_n=%b code=%b key_valid=%b, want %b %b %b",
                   k, cyc, bus.row_n, bus.code, bus.key_valid, exp_row_n(), m_code, m_valid);
        end
        if (pressed && keys[9+k]) held++;
        if (bus.key_valid === 1'b1) seen.push_back(bus.code);
      end
      keys[9+k] = 1'b0;
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL special%0d_timeout: release not completed, want completion", k);
      end
    end
    vectors++;
    if (seen.size() != 3) begin
      miscompares++;
      $display("FAIL special_count: %0d pulses, want 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (seen[i] !== want[i]) begin
          miscompares++;
          $display("FAIL special_order[%0d]: code=%b, want %b", i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_multi_key();
    int pulses, changes, start;
    logic [3:0] prev;
    pulses = 0; changes = 0; prev = bus.row_n;
    start = int'($urandom_range(0, 5));
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (cyc == start)       begin keys[0] = 1'b1; keys[1] = 1'b1; end
      if (cyc == start + 100) begin keys[0] = 1'b0; keys[1] = 1'b0; end
      @(negedge clk);
      vectors++;
      if (bus.row_n !== exp_row_n() || bus.code !== m_code || bus.key_valid !== m_valid) begin
        miscompares++;
        $display("FAIL multikey cycle %0d: row_n=%b code=%b key_valid=%b, want %b %b %b",
                 cyc, bus.row_n, bus.code, bus.key_valid, exp_row_n(), m_code, m_valid);
      end
      if (bus.key_valid === 1'b1) pulses++;
      if (bus.row_n !== prev && cyc >= start && cyc < start + 100) changes++;
      prev = bus.row_n;
    end
    vectors++;
    if (pulses != 0 || changes < 20) begin
      miscompares++;
      $display("FAIL multikey_ghost: pulses=%0d row changes=%0d, want 0 and >=20", pulses, changes);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int pulses;
    bit pressed, hit;
    logic [3:0] got;
    pressed = 1'b0; hit = 1'b0; pulses = 0; got = IDLE;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      if (!pressed && !m_locked && m_row != 2) begin
        keys[8] = 1'b1; pressed = 1'b1;
      end
      @(negedge clk);
      vectors++;
      if (bus.row_n !== exp_row_n() || bus.code !== m_code || bus.key_valid !== m_valid) begin
        miscompares++;
        $display("FAIL rst9_pre cycle %0d: row_n=%b code=%b key_valid=%b, want %b %b %b",
                 cyc, bus.row_n, bus.code, bus.key_valid, exp_row_n(), m_code, m_valid);
      end
      if (m_locked && !m_pressed && m_stable == 4) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rst9_reach: debounce of key 9 not reached, want reached");
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.row_n !== 4'b1110 || bus.code !== IDLE || bus.key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst9_async: row_n=%b code=%b key_valid=%b, want 1110 1111 0",
               bus.row_n, bus.code, bus.key_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (cyc == 80) keys[8] = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.row_n !== exp_row_n() || bus.code !== m_code || bus.key_valid !== m_valid) begin
        miscompares++;
        $display("FAIL rst9_post cycle %0d: row_n=%b code=%b key_valid=%b, want %b %b %b",
                 cyc, bus.row_n, bus.code, bus.key_valid, exp_row_n(), m_code, m_valid);
      end
      if (bus.key_valid === 1'b1) begin
        pulses++; got = bus.code;
      end
    end
    vectors++;
    if (pulses != 1 || got !== 4'b1001) begin
      miscompares++;
      $display("FAIL rst9_pulse: pulses=%0d code=%b, want 1 1001", pulses, got);
    end
  endtask

  initial begin
    test_reset();
    test_press_five();
    test_bounce_seven();
    test_special_keys();
    test_multi_key();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
